// File: rtl/vga_pkg.sv
// Shared raster timing definitions for the VGA path: default 640x480@60 timing,
// coordinate type and the delayed sync/blank bundle.
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int COORD_RANGE = 1024;

    localparam int DEF_H_ACTIVE      = 640;
    localparam int DEF_H_FRONT       = 16;
    localparam int DEF_H_SYNC        = 96;
    localparam int DEF_H_BACK        = 48;
    localparam int DEF_V_ACTIVE      = 480;
    localparam int DEF_V_FRONT       = 10;
    localparam int DEF_V_SYNC        = 2;
    localparam int DEF_V_BACK        = 33;
    localparam int DEF_DISPLAY_DELAY = 2;

    typedef struct packed {
        logic video;
        logic hs;
        logic vs;
    } disp_t;

    localparam disp_t DISP_RESET = '{video: 1'b0, hs: 1'b1, vs: 1'b1};

    function automatic int h_total(input int active, input int front, input int sync, input int back);
        return active + front + sync + back;
    endfunction

    function automatic int v_total(input int active, input int front, input int sync, input int back);
        return active + front + sync + back;
    endfunction

    // True while v lies in [start, start+len).
    function automatic logic in_window(input coord_t v, input int start, input int len);
        return (int'(v) >= start) && (int'(v) < start + len);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter: advances on inc_i, wraps MAX -> 0 and flags the wrap.
module wrap_counter
    import vga_pkg::*;
#(
    parameter int MAX = 799
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   inc_i,
    input  logic   clear_i,
    output coord_t value_o,
    output logic   wrap_o
);

    coord_t value_q, value_d;

    assign wrap_o  = inc_i && (int'(value_q) == MAX);
    assign value_o = value_q;

    always_comb begin
        // NOTE: hold value assigned first so every path drives value_d and no latch is inferred.
        value_d = value_q;
        if (clear_i || wrap_o) begin
            value_d = '0;
        end else if (inc_i) begin
            value_d = value_q + coord_t'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: halves CLK_50 into a pixel tick, scans the frame and
// delays sync/blank so they line up with screen RAM read data.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE      = DEF_H_ACTIVE,
    parameter int H_FRONT       = DEF_H_FRONT,
    parameter int H_SYNC        = DEF_H_SYNC,
    parameter int H_BACK        = DEF_H_BACK,
    parameter int V_ACTIVE      = DEF_V_ACTIVE,
    parameter int V_FRONT       = DEF_V_FRONT,
    parameter int V_SYNC        = DEF_V_SYNC,
    parameter int V_BACK        = DEF_V_BACK,
    parameter int DISPLAY_DELAY = DEF_DISPLAY_DELAY
) (
    input  logic   CLK_50,
    input  logic   rst_n,
    output coord_t pixel_x,
    output coord_t pixel_y,
    output logic   pix_en,
    output logic   fetch_on,
    output logic   video_on,
    output logic   h_sync,
    output logic   v_sync,
    output logic   frame_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

    if (H_TOTAL > COORD_RANGE || V_TOTAL > COORD_RANGE) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
    end
    if (DISPLAY_DELAY < 0 || DISPLAY_DELAY > 7) begin : g_bad_delay
        $error("vga_timing_gen: DISPLAY_DELAY must be 0..7");
    end

    logic   toggle_q, pix_en_q, run_q, frame_start_q;
    logic   x_wrap, y_wrap;
    disp_t  raw, disp;

    // run_q keeps fetch_on low while the block sits in reset at (0,0).
    always_ff @(posedge CLK_50 or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q      <= 1'b0;
            pix_en_q      <= 1'b0;
            run_q         <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            toggle_q      <= ~toggle_q;
            pix_en_q      <= toggle_q;
            run_q         <= 1'b1;
            frame_start_q <= x_wrap & y_wrap;
        end
    end

    wrap_counter #(.MAX(H_TOTAL - 1)) u_x_cnt (
        .clk     (CLK_50),
        .rst_n   (rst_n),
        .inc_i   (pix_en_q),
        .clear_i (1'b0),
        .value_o (pixel_x),
        .wrap_o  (x_wrap)
    );

    wrap_counter #(.MAX(V_TOTAL - 1)) u_y_cnt (
        .clk     (CLK_50),
        .rst_n   (rst_n),
        .inc_i   (x_wrap),
        .clear_i (1'b0),
        .value_o (pixel_y),
        .wrap_o  (y_wrap)
    );

    always_comb begin
        raw       = DISP_RESET;
        raw.video = run_q && (int'(pixel_x) < H_ACTIVE) && (int'(pixel_y) < V_ACTIVE);
        raw.hs    = ~in_window(pixel_x, H_ACTIVE + H_FRONT, H_SYNC);
        raw.vs    = ~in_window(pixel_y, V_ACTIVE + V_FRONT, V_SYNC);
    end

    if (DISPLAY_DELAY == 0) begin : g_no_delay
        assign disp = raw;
    end else begin : g_delay
        disp_t dly_q [DISPLAY_DELAY];

        // NOTE: the delay stages drive outputs directly, so each is reset to the idle sync/blank value.
        always_ff @(posedge CLK_50 or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DISPLAY_DELAY; i++) dly_q[i] <= DISP_RESET;
            end else if (pix_en_q) begin
                dly_q[0] <= raw;
                for (int i = 1; i < DISPLAY_DELAY; i++) dly_q[i] <= dly_q[i-1];
            end
        end

        assign disp = dly_q[DISPLAY_DELAY-1];
    end

    assign pix_en      = pix_en_q;
    assign fetch_on    = raw.video;
    assign video_on    = disp.video;
    assign h_sync      = disp.hs;
    assign v_sync      = disp.vs;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default timing plus two small-raster instances
// (delay 0 and 3) scored every cycle against an arithmetic raster model.
module tb_vga_timing_gen;
    import vga_pkg::*;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        int dd;
    } timing_t;

    typedef struct packed {
        logic       pix_en;
        logic [9:0] x;
        logic [9:0] y;
        logic       fetch;
        logic       video;
        logic       hs;
        logic       vs;
        logic       fs;
    } obs_t;

    typedef struct {
        int   n;
        logic pe;
        int   x;
        int   y;
        logic vid;
        logic hs;
    } vec_t;

    localparam timing_t P_DEF = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
    localparam timing_t P_S0  = '{8, 2, 3, 3, 6, 1, 2, 2, 0};
    localparam timing_t P_S3  = '{8, 2, 3, 3, 6, 1, 2, 2, 3};
    localparam int SMALL_FRAME_CYC = 2 * 16 * 11;

    logic CLK_50 = 1'b0;
    logic rst_n  = 1'b0;

    always #10 CLK_50 = ~CLK_50;

    coord_t x_def, y_def, x_s0, y_s0, x_s3, y_s3;
    logic   pe_def, fo_def, vo_def, hs_def, vs_def, fs_def;
    logic   pe_s0, fo_s0, vo_s0, hs_s0, vs_s0, fs_s0;
    logic   pe_s3, fo_s3, vo_s3, hs_s3, vs_s3, fs_s3;

    vga_timing_gen dut (
        .CLK_50(CLK_50), .rst_n(rst_n), .pixel_x(x_def), .pixel_y(y_def), .pix_en(pe_def),
        .fetch_on(fo_def), .video_on(vo_def), .h_sync(hs_def), .v_sync(vs_def), .frame_start(fs_def)
    );

    vga_timing_gen #(
        .H_ACTIVE(P_S0.ha), .H_FRONT(P_S0.hf), .H_SYNC(P_S0.hs), .H_BACK(P_S0.hb),
        .V_ACTIVE(P_S0.va), .V_FRONT(P_S0.vf), .V_SYNC(P_S0.vs), .V_BACK(P_S0.vb),
        .DISPLAY_DELAY(P_S0.dd)
    ) dut_s0 (
        .CLK_50(CLK_50), .rst_n(rst_n), .pixel_x(x_s0), .pixel_y(y_s0), .pix_en(pe_s0),
        .fetch_on(fo_s0), .video_on(vo_s0), .h_sync(hs_s0), .v_sync(vs_s0), .frame_start(fs_s0)
    );

    vga_timing_gen #(
        .H_ACTIVE(P_S3.ha), .H_FRONT(P_S3.hf), .H_SYNC(P_S3.hs), .H_BACK(P_S3.hb),
        .V_ACTIVE(P_S3.va), .V_FRONT(P_S3.vf), .V_SYNC(P_S3.vs), .V_BACK(P_S3.vb),
        .DISPLAY_DELAY(P_S3.dd)
    ) dut_s3 (
        .CLK_50(CLK_50), .rst_n(rst_n), .pixel_x(x_s3), .pixel_y(y_s3), .pix_en(pe_s3),
        .fetch_on(fo_s3), .video_on(vo_s3), .h_sync(hs_s3), .v_sync(vs_s3), .frame_start(fs_s3)
    );

    obs_t obs_def, obs_s0, obs_s3;
    assign obs_def = '{pe_def, x_def, y_def, fo_def, vo_def, hs_def, vs_def, fs_def};
    assign obs_s0  = '{pe_s0, x_s0, y_s0, fo_s0, vo_s0, hs_s0, vs_s0, fs_s0};
    assign obs_s3  = '{pe_s3, x_s3, y_s3, fo_s3, vo_s3, hs_s3, vs_s3, fs_s3};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT event (time %0t)", name, $time);
    endtask

    // Raster model: n = CLK_50 edges since reset release. Ticks complete on odd
    // edges from the 3rd on; outputs reflect the raster position DISPLAY_DELAY ticks ago.
    function automatic obs_t model(input timing_t p, input int n);
        obs_t o;
        int ht, vt, t, x, y, dt, dx, dy;
        ht = p.ha + p.hf + p.hs + p.hb;
        vt = p.va + p.vf + p.vs + p.vb;
        t  = (n >= 3) ? (n - 1) / 2 : 0;
        x  = t % ht;
        y  = (t / ht) % vt;
        o.pix_en = (n >= 2) && (n % 2 == 0);
        o.x      = 10'(x);
        o.y      = 10'(y);
        o.fetch  = (n >= 1) && (x < p.ha) && (y < p.va);
        o.fs     = (n >= 3) && (n % 2 == 1) && (t % (ht * vt) == 0);
        dt = t - p.dd;
        if (dt < 0) begin
            o.video = 1'b0;
            o.hs    = 1'b1;
            o.vs    = 1'b1;
        end else begin
            dx = dt % ht;
            dy = (dt / ht) % vt;
            o.video = (n >= 1) && (dx < p.ha) && (dy < p.va);
            o.hs    = !((dx >= p.ha + p.hf) && (dx < p.ha + p.hf + p.hs));
            o.vs    = !((dy >= p.va + p.vf) && (dy < p.va + p.vf + p.vs));
        end
        return o;
    endfunction

    task automatic cmp_obs(input string tag, input obs_t act, input obs_t exp);
        check({tag, ".pix_en"},      32'(act.pix_en), 32'(exp.pix_en));
        check({tag, ".pixel_x"},     32'(act.x),      32'(exp.x));
        check({tag, ".pixel_y"},     32'(act.y),      32'(exp.y));
        check({tag, ".fetch_on"},    32'(act.fetch),  32'(exp.fetch));
        check({tag, ".video_on"},    32'(act.video),  32'(exp.video));
        check({tag, ".h_sync"},      32'(act.hs),     32'(exp.hs));
        check({tag, ".v_sync"},      32'(act.vs),     32'(exp.vs));
        check({tag, ".frame_start"}, 32'(act.fs),     32'(exp.fs));
    endtask

    int n_edge = 0;
    always @(posedge CLK_50 or negedge rst_n) begin
        if (!rst_n) n_edge <= 0;
        else        n_edge <= n_edge + 1;
    end

    bit sb_on = 1'b0;
    always @(negedge CLK_50) begin
        if (sb_on) begin
            cmp_obs("sb.def", obs_def, model(P_DEF, n_edge));
            cmp_obs("sb.s0",  obs_s0,  model(P_S0,  n_edge));
            cmp_obs("sb.s3",  obs_s3,  model(P_S3,  n_edge));
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs[$];

    initial begin
        int guard, cnt, vs_low, vid_high;

        // Hand-derived points on the default raster (DISPLAY_DELAY = 2).
        vecs.push_back('{1,    1'b0, 0,   0, 1'b0, 1'b1});
        vecs.push_back('{2,    1'b1, 0,   0, 1'b0, 1'b1});
        vecs.push_back('{3,    1'b0, 1,   0, 1'b0, 1'b1});
        vecs.push_back('{4,    1'b1, 1,   0, 1'b0, 1'b1});
        vecs.push_back('{5,    1'b0, 2,   0, 1'b1, 1'b1});
        vecs.push_back('{1284, 1'b1, 641, 0, 1'b1, 1'b1});
        vecs.push_back('{1285, 1'b0, 642, 0, 1'b0, 1'b1});
        vecs.push_back('{1316, 1'b1, 657, 0, 1'b0, 1'b1});
        vecs.push_back('{1317, 1'b0, 658, 0, 1'b0, 1'b0});
        vecs.push_back('{1508, 1'b1, 753, 0, 1'b0, 1'b0});
        vecs.push_back('{1509, 1'b0, 754, 0, 1'b0, 1'b1});
        vecs.push_back('{1600, 1'b1, 799, 0, 1'b0, 1'b1});
        vecs.push_back('{1601, 1'b0, 0,   1, 1'b0, 1'b1});
        vecs.push_back('{1605, 1'b0, 2,   1, 1'b1, 1'b1});

        rst_n = 1'b0;
        repeat (3) @(negedge CLK_50);
        check("reset.pixel_x",     32'(x_def),  0);
        check("reset.pixel_y",     32'(y_def),  0);
        check("reset.pix_en",      32'(pe_def), 0);
        check("reset.fetch_on",    32'(fo_def), 0);
        check("reset.video_on",    32'(vo_def), 0);
        check("reset.h_sync",      32'(hs_def), 1);
        check("reset.v_sync",      32'(vs_def), 1);
        check("reset.frame_start", 32'(fs_def), 0);

        sb_on = 1'b1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            guard = 0;
            while (n_edge != vecs[i].n && guard < 5000) begin
                @(negedge CLK_50);
                guard++;
            end
            if (n_edge != vecs[i].n) begin
                timeout_fail($sformatf("vec%0d.reach", i));
            end else begin
                check($sformatf("vec%0d.pix_en", i),   32'(pe_def), 32'(vecs[i].pe));
                check($sformatf("vec%0d.pixel_x", i),  32'(x_def),  32'(vecs[i].x));
                check($sformatf("vec%0d.pixel_y", i),  32'(y_def),  32'(vecs[i].y));
                check($sformatf("vec%0d.video_on", i), 32'(vo_def), 32'(vecs[i].vid));
                check($sformatf("vec%0d.h_sync", i),   32'(hs_def), 32'(vecs[i].hs));
            end
        end

        // h_sync pulse width on line 1 of the default raster.
        guard = 0;
        while (hs_def !== 1'b0 && guard < 4000) begin @(negedge CLK_50); guard++; end
        if (hs_def !== 1'b0) timeout_fail("hsync.fall");
        else begin
            check("hsync.fall_x", 32'(x_def), 658);
            cnt = 0;
            while (hs_def === 1'b0 && cnt < 1000) begin @(negedge CLK_50); cnt++; end
            check("hsync.low_cycles", 32'(cnt), 192);
        end

        // Frame period, v_sync width and visible area on the delay-3 small raster.
        guard = 0;
        while (fs_s3 !== 1'b1 && guard < 2000) begin @(negedge CLK_50); guard++; end
        if (fs_s3 !== 1'b1) timeout_fail("frame.first_pulse");
        else begin
            cnt = 0; vs_low = 0; vid_high = 0;
            do begin
                @(negedge CLK_50);
                cnt++;
                if (vs_s3 === 1'b0) vs_low++;
                if (vo_s3 === 1'b1) vid_high++;
            end while (fs_s3 !== 1'b1 && cnt < 2000);
            check("frame.period_cycles", 32'(cnt),      SMALL_FRAME_CYC);
            check("frame.vsync_low",     32'(vs_low),   2 * 16 * 2);
            check("frame.video_high",    32'(vid_high), 6 * 8 * 2);
        end

        // DISPLAY_DELAY = 3: video_on rises 3 ticks after fetch_on.
        guard = 0;
        while (fo_s3 !== 1'b0 && guard < 200) begin @(negedge CLK_50); guard++; end
        while (fo_s3 !== 1'b1 && guard < 400) begin @(negedge CLK_50); guard++; end
        if (fo_s3 !== 1'b1) timeout_fail("delay3.fetch_rise");
        else begin
            check("delay3.video_before", 32'(vo_s3), 0);
            cnt = 0;
            while (vo_s3 !== 1'b1 && cnt < 100) begin @(negedge CLK_50); cnt++; end
            check("delay3.rise_cycles", 32'(cnt), 6);
        end

        // Mid-frame reset inside v sync on the delay-0 raster.
        guard = 0;
        while (!(x_s0 == 10'd12 && y_s0 == 10'd7) && guard < 2000) begin @(negedge CLK_50); guard++; end
        if (!(x_s0 == 10'd12 && y_s0 == 10'd7)) timeout_fail("midreset.reach");
        else begin
            check("midreset.vsync_before", 32'(vs_s0), 0);
            #2;
            rst_n = 1'b0;
            #1;
            check("midreset.pixel_x",     32'(x_s0),  0);
            check("midreset.pixel_y",     32'(y_s0),  0);
            check("midreset.v_sync",      32'(vs_s0), 1);
            check("midreset.h_sync",      32'(hs_s0), 1);
            check("midreset.video_on",    32'(vo_s0), 0);
            check("midreset.pix_en",      32'(pe_s0), 0);
            check("midreset.s3_v_sync",   32'(vs_s3), 1);
            check("midreset.def_pixel_x", 32'(x_def), 0);
            repeat (2) @(negedge CLK_50);
            rst_n = 1'b1;
            @(negedge CLK_50);
            check("restart.pixel_x",     32'(x_s0),  0);
            check("restart.pixel_y",     32'(y_s0),  0);
            check("restart.frame_start", 32'(fs_s0), 0);
        end

        // Three more small frames under the per-cycle scoreboard.
        repeat (3 * SMALL_FRAME_CYC + 20) @(negedge CLK_50);
        sb_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
